// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: oversampled UART receiver with configurable data width, parity and stop bits.
// Define UART_RX_CFG_BREAK_DET_EN to add the break_det output and suppress data_valid on breaks.
module uart_rx_cfg #(
    parameter int CLOCK_FREQ = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
`ifdef UART_RX_CFG_BREAK_DET_EN
    ,
    output logic                 break_det
`endif
);
    localparam int TICK_DIV_RAW = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int TICK_DIV     = (TICK_DIV_RAW < 1) ? 1 : TICK_DIV_RAW;
    localparam int DIV_W        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SMP_W        = $clog2(OVERSAMPLE);
    localparam int BIT_W        = $clog2(DATA_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
    localparam logic [SMP_W-1:0] SMP_A     = SMP_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SMP_W-1:0] SMP_B     = SMP_W'(OVERSAMPLE / 2);
    localparam logic [SMP_W-1:0] SMP_C     = SMP_W'(OVERSAMPLE / 2 + 1);
    localparam logic [SMP_W-1:0] SMP_LAST  = SMP_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_rx_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_rx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
    end
    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
        $error("uart_rx_cfg: OVERSAMPLE must be even and >= 8");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t               state;
    logic                 rx_meta, rx_s, rx_prev;
    logic [1:0]           settle;
    logic [DIV_W-1:0]     div_cnt;
    logic [SMP_W-1:0]     smp_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic                 stop_cnt;
    logic                 s0, s1;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bad, frame_bad;
    logic                 tick, vote, fe_now, deliver;

    assign busy   = (state != S_IDLE);
    assign tick   = busy && (div_cnt == DIV_LAST);
    assign vote   = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
    assign fe_now = frame_bad | ~vote;

`ifdef UART_RX_CFG_BREAK_DET_EN
    logic par_bit, is_break;
    assign is_break = (shreg == '0) && !par_bit && fe_now;
    assign deliver  = !is_break;
`else
    assign deliver  = 1'b1;
`endif

    // NOTE: every register here uses <= so all flops see pre-edge values; where a state
    // branch below re-assigns a counter, that later non-blocking write takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            rx_meta    <= 1'b1;
            rx_s       <= 1'b1;
            rx_prev    <= 1'b1;
            settle     <= '0;
            div_cnt    <= '0;
            smp_cnt    <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            s0         <= 1'b1;
            s1         <= 1'b1;
            shreg      <= '0;
            par_bad    <= 1'b0;
            frame_bad  <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_CFG_BREAK_DET_EN
            par_bit    <= 1'b0;
            break_det  <= 1'b0;
`endif
        end else begin
            rx_meta    <= rx;
            rx_s       <= rx_meta;
            rx_prev    <= rx_s;
            data_valid <= 1'b0;
`ifdef UART_RX_CFG_BREAK_DET_EN
            break_det  <= 1'b0;
`endif
            // rx_prev only holds a real line sample from the third cycle after reset release
            if (settle != 2'd3)
                settle <= settle + 2'd1;
            if (busy)
                div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            if (tick) begin
                smp_cnt <= (smp_cnt == SMP_LAST) ? '0 : smp_cnt + SMP_W'(1);
                if (smp_cnt == SMP_A) s0 <= rx_s;
                if (smp_cnt == SMP_B) s1 <= rx_s;
            end

            case (state)
                S_IDLE: begin
                    if (settle == 2'd3 && rx_prev && !rx_s) begin
                        state     <= S_START;
                        div_cnt   <= '0;
                        smp_cnt   <= '0;
                        par_bad   <= 1'b0;
                        frame_bad <= 1'b0;
`ifdef UART_RX_CFG_BREAK_DET_EN
                        par_bit   <= 1'b0;
`endif
                    end
                end
                S_START: begin
                    if (tick) begin
                        if (smp_cnt == SMP_C && vote) begin
                            state <= S_IDLE;
                        end else if (smp_cnt == SMP_LAST) begin
                            state   <= S_DATA;
                            bit_cnt <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        if (smp_cnt == SMP_C)
                            shreg <= {vote, shreg[DATA_BITS-1:1]};
                        if (smp_cnt == SMP_LAST) begin
                            if (bit_cnt == BIT_LAST) begin
                                state    <= (PARITY != 0) ? S_PARITY : S_STOP;
                                stop_cnt <= 1'b0;
                            end else begin
                                bit_cnt <= bit_cnt + BIT_W'(1);
                            end
                        end
                    end
                end
                S_PARITY: begin
                    if (tick) begin
                        if (smp_cnt == SMP_C) begin
                            // odd mode wants XOR(payload, parity) = 1, even mode wants 0
                            par_bad <= (^shreg) ^ vote ^ (PARITY == 1);
`ifdef UART_RX_CFG_BREAK_DET_EN
                            par_bit <= vote;
`endif
                        end
                        if (smp_cnt == SMP_LAST)
                            state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        if (smp_cnt == SMP_C && stop_cnt == STOP_LAST) begin
                            if (deliver) begin
                                data_valid <= 1'b1;
                                data_out   <= shreg;
                                parity_err <= par_bad;
                                frame_err  <= fe_now;
                            end
`ifdef UART_RX_CFG_BREAK_DET_EN
                            break_det <= is_break;
`endif
                            state   <= fe_now ? S_WAIT_IDLE : S_IDLE;
                            div_cnt <= '0;
                            smp_cnt <= '0;
                        end else if (smp_cnt == SMP_C) begin
                            frame_bad <= fe_now;
                        end else if (smp_cnt == SMP_LAST) begin
                            stop_cnt <= 1'b1;
                        end
                    end
                end
                S_WAIT_IDLE: begin
                    // any low sample restarts the full idle bit period
                    if (!rx_s) begin
                        div_cnt <= '0;
                        smp_cnt <= '0;
                    end else if (tick && smp_cnt == SMP_LAST) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: three configurations (8N1, 8E1, 7N2) at 64 clocks per bit.
// Stimulus pushes expected frames into per-instance queues; monitors pop on data_valid.
module tb_uart_rx_cfg;
    localparam int CLK_HZ = 6400000;
    localparam int BAUD   = 100000;
    localparam int OS     = 16;
    localparam int BIT    = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] rx_line = 3'b111;

    logic [7:0] d0, d1;
    logic [6:0] d2;
    logic       dv0, dv1, dv2, pe0, pe1, pe2, fe0, fe1, fe2, busy0, busy1, busy2;
`ifdef UART_RX_CFG_BREAK_DET_EN
    logic       brk0, brk1, brk2;
    int         exp_brk = 0;
`endif

    typedef struct packed {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t q0[$], q1[$], q2[$];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    uart_rx_cfg #(.CLOCK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .OVERSAMPLE(OS)) u0 (
        .clk(clk), .rst_n(rst_n), .rx(rx_line[0]), .data_out(d0), .data_valid(dv0),
        .parity_err(pe0), .frame_err(fe0), .busy(busy0)
`ifdef UART_RX_CFG_BREAK_DET_EN
        , .break_det(brk0)
`endif
    );

    uart_rx_cfg #(.CLOCK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(2),
                  .STOP_BITS(1), .OVERSAMPLE(OS)) u1 (
        .clk(clk), .rst_n(rst_n), .rx(rx_line[1]), .data_out(d1), .data_valid(dv1),
        .parity_err(pe1), .frame_err(fe1), .busy(busy1)
`ifdef UART_RX_CFG_BREAK_DET_EN
        , .break_det(brk1)
`endif
    );

    uart_rx_cfg #(.CLOCK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(7), .PARITY(0),
                  .STOP_BITS(2), .OVERSAMPLE(OS)) u2 (
        .clk(clk), .rst_n(rst_n), .rx(rx_line[2]), .data_out(d2), .data_valid(dv2),
        .parity_err(pe2), .frame_err(fe2), .busy(busy2)
`ifdef UART_RX_CFG_BREAK_DET_EN
        , .break_det(brk2)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int inst, input logic [8:0] data, input logic perr, input logic ferr);
        exp_t e;
        e = '{data: data, perr: perr, ferr: ferr};
        case (inst)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic pop_cmp(input int inst, input logic [8:0] data, input logic perr, input logic ferr);
        exp_t e;
        logic have;
        have = 1'b0;
        e = '0;
        case (inst)
            0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        check($sformatf("u%0d valid_expected", inst), 32'(have), 32'd1);
        if (have) begin
            check($sformatf("u%0d data_out", inst), 32'(data), 32'(e.data));
            check($sformatf("u%0d parity_err", inst), 32'(perr), 32'(e.perr));
            check($sformatf("u%0d frame_err", inst), 32'(ferr), 32'(e.ferr));
        end
    endtask

    always @(negedge clk) begin
        if (dv0) pop_cmp(0, {1'b0, d0}, pe0, fe0);
        if (dv1) pop_cmp(1, {1'b0, d1}, pe1, fe1);
        if (dv2) pop_cmp(2, {2'b00, d2}, pe2, fe2);
`ifdef UART_RX_CFG_BREAK_DET_EN
        if (brk0) begin
            check("u0 break_expected", 32'(exp_brk > 0), 32'd1);
            if (exp_brk > 0) exp_brk--;
        end
        if (brk1 || brk2) check("u1/u2 break_unexpected", 32'd1, 32'd0);
`endif
    end

    // Drives bits LSB-first; optionally flips the line for 2 clocks mid-way through one bit.
    task automatic send_frame(input int inst, input logic [15:0] bits, input int n, input int glitch_at);
        for (int i = 0; i < n; i++) begin
            rx_line[inst] = bits[i];
            if (i == glitch_at) begin
                repeat (BIT / 2 - 1) @(negedge clk);
                rx_line[inst] = ~bits[i];
                repeat (2) @(negedge clk);
                rx_line[inst] = bits[i];
                repeat (BIT / 2 - 1) @(negedge clk);
            end else begin
                repeat (BIT) @(negedge clk);
            end
        end
    endtask

    initial begin
        int waited;

        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        check("reset data_out", 32'(d0), 32'd0);
        check("reset busy", 32'({busy0, busy1, busy2}), 32'd0);
        check("reset flags", 32'({dv0, pe0, fe0, dv1, pe1, fe1, dv2, pe2, fe2}), 32'd0);
        rst_n = 1'b1;
        repeat (2 * BIT) @(negedge clk);

        // 8N1 back-to-back frames
        push(0, 9'h0A5, 1'b0, 1'b0);
        push(0, 9'h03C, 1'b0, 1'b0);
        send_frame(0, {6'b0, 1'b1, 8'hA5, 1'b0}, 10, -1);
        send_frame(0, {6'b0, 1'b1, 8'h3C, 1'b0}, 10, -1);
        repeat (BIT) @(negedge clk);
        check("u0 data_out hold", 32'(d0), 32'h3C);

        // 8E1: correct then wrong parity bit
        push(1, 9'h03C, 1'b0, 1'b0);
        push(1, 9'h03C, 1'b1, 1'b0);
        send_frame(1, {5'b0, 1'b1, 1'b0, 8'h3C, 1'b0}, 11, -1);
        send_frame(1, {5'b0, 1'b1, 1'b1, 8'h3C, 1'b0}, 11, -1);
        repeat (BIT) @(negedge clk);

        // 7N2 with second stop bit low, then hold low before releasing
        push(2, 9'h055, 1'b0, 1'b1);
        send_frame(2, {6'b0, 1'b0, 1'b1, 7'h55, 1'b0}, 10, -1);
        check("u2 busy in wait_idle", 32'(busy2), 32'd1);
        repeat (BIT) @(negedge clk);
        check("u2 busy while low", 32'(busy2), 32'd1);
        rx_line[2] = 1'b1;
        repeat (48) @(negedge clk);
        check("u2 busy before idle period", 32'(busy2), 32'd1);
        repeat (32) @(negedge clk);
        check("u2 busy after idle period", 32'(busy2), 32'd0);

        // short low glitch on idle line
        rx_line[0] = 1'b0;
        repeat (3) @(negedge clk);
        rx_line[0] = 1'b1;
        repeat (7) @(negedge clk);
        check("u0 glitch enters start", 32'(busy0), 32'd1);
        repeat (BIT - 10) @(negedge clk);
        check("u0 glitch rejected", 32'(busy0), 32'd0);
        repeat (BIT) @(negedge clk);

        // mid-bit glitch inside a 0x81 frame (data bit 3)
        push(0, 9'h081, 1'b0, 1'b0);
        send_frame(0, {6'b0, 1'b1, 8'h81, 1'b0}, 10, 4);
        repeat (BIT) @(negedge clk);

        // reset during data bit 4 while line is low
        send_frame(0, {10'b0, 4'hF, 1'b0}, 5, -1);
        rx_line[0] = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midframe reset data_out", 32'(d0), 32'd0);
        check("midframe reset busy", 32'(busy0), 32'd0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        check("low line after reset ignored", 32'(busy0), 32'd0);
        rx_line[0] = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        push(0, 9'h05A, 1'b0, 1'b0);
        send_frame(0, {6'b0, 1'b1, 8'h5A, 1'b0}, 10, -1);
        repeat (BIT) @(negedge clk);

        // break: line low for 12 bit periods
`ifdef UART_RX_CFG_BREAK_DET_EN
        exp_brk = 1;
`else
        push(0, 9'h000, 1'b0, 1'b1);
`endif
        rx_line[0] = 1'b0;
        repeat (12 * BIT) @(negedge clk);
        check("u0 busy during break", 32'(busy0), 32'd1);
        rx_line[0] = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        check("u0 idle after break", 32'(busy0), 32'd0);
        push(0, 9'h011, 1'b0, 1'b0);
        send_frame(0, {6'b0, 1'b1, 8'h11, 1'b0}, 10, -1);

        waited = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && waited < 4 * BIT) begin
            @(negedge clk);
            waited++;
        end
        check("u0 pending frames", 32'(q0.size()), 32'd0);
        check("u1 pending frames", 32'(q1.size()), 32'd0);
        check("u2 pending frames", 32'(q2.size()), 32'd0);
`ifdef UART_RX_CFG_BREAK_DET_EN
        check("u0 pending breaks", 32'(exp_brk), 32'd0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
